// File: rtl/piano_key_debounce.sv
// piano_key_debounce
//   Synchronises and debounces eight raw piano key inputs (t0..t7) and offers
//   each new stable chord to the LISTEN stage over a valid/ready handshake.
//   Bit order everywhere is {t0,...,t7}, so t0 lands in bit 7.
//   Optional build macro: KEY_ACTIVE_LOW_EN -- raw keys are active-low
//   (pull-up switches) and are inverted before synchronisation.
module piano_key_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int CNT_W           = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       t0,
  input  logic       t1,
  input  logic       t2,
  input  logic       t3,
  input  logic       t4,
  input  logic       t5,
  input  logic       t6,
  input  logic       t7,
  output logic [7:0] keys_stable,
  output logic [7:0] chord,
  output logic       chord_valid,
  input  logic       chord_ready
);

  localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LP_CNT_ONE  = CNT_W'(1);

  typedef enum logic {
    ST_IDLE,
    ST_PEND
  } state_t;

  logic [7:0]       w_raw;
  logic [7:0]       r_sync1;
  logic [7:0]       r_sync2;
  logic [7:0]       r_keys_stable;
  logic [CNT_W-1:0] r_cnt [8];
  logic [7:0]       r_chord;
  logic [7:0]       r_last_sent;
  logic             r_chord_valid;
  state_t           r_state;

`ifdef KEY_ACTIVE_LOW_EN
  assign w_raw = ~{t0, t1, t2, t3, t4, t5, t6, t7};
`else
  assign w_raw = {t0, t1, t2, t3, t4, t5, t6, t7};
`endif

  // Two-flop synchroniser for the asynchronous key inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Per-key debounce: a key must disagree with its stable level for
  // DEBOUNCE_CYCLES consecutive cycles before the stable level flips.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_keys_stable <= '0;
      for (int unsigned i = 0; i < 8; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < 8; i++) begin
        if (r_sync2[i] == r_keys_stable[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == LP_CNT_LAST) begin
          r_keys_stable[i] <= ~r_keys_stable[i];
          r_cnt[i]         <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + LP_CNT_ONE;
        end
      end
    end
  end

  // Chord publisher: offers the latest stable chord whenever it differs from
  // the last one sent; changes while a chord is pending are coalesced.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_chord       <= '0;
      r_last_sent   <= '0;
      r_chord_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (r_keys_stable != r_last_sent) begin
            r_chord       <= r_keys_stable;
            r_last_sent   <= r_keys_stable;
            r_chord_valid <= 1'b1;
            r_state       <= ST_PEND;
          end else begin
            r_chord_valid <= 1'b0;
          end
        end
        ST_PEND: begin
          if (chord_ready) begin
            r_chord_valid <= 1'b0;
            r_state       <= ST_IDLE;
          end
        end
        default: begin
          r_chord_valid <= 1'b0;
          r_state       <= ST_IDLE;
        end
      endcase
    end
  end

  assign keys_stable = r_keys_stable;
  assign chord       = r_chord;
  assign chord_valid = r_chord_valid;

endmodule

// File: tb/tb_piano_key_debounce.sv
// tb_piano_key_debounce
//   Self-checking bench for piano_key_debounce with DEBOUNCE_CYCLES=4.
//   Honours KEY_ACTIVE_LOW_EN: idle raw level and press polarity follow it.
module tb_piano_key_debounce;

  localparam int D = 4;
`ifdef KEY_ACTIVE_LOW_EN
  localparam logic [7:0] IDLE_RAW = 8'hFF;
`else
  localparam logic [7:0] IDLE_RAW = 8'h00;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] raw = IDLE_RAW;
  logic       chord_ready = 1'b0;
  logic [7:0] keys_stable;
  logic [7:0] chord;
  logic       chord_valid;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  piano_key_debounce #(
    .DEBOUNCE_CYCLES(D),
    .CNT_W(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .t0(raw[7]),
    .t1(raw[6]),
    .t2(raw[5]),
    .t3(raw[4]),
    .t4(raw[3]),
    .t5(raw[2]),
    .t6(raw[1]),
    .t7(raw[0]),
    .keys_stable(keys_stable),
    .chord(chord),
    .chord_valid(chord_valid),
    .chord_ready(chord_ready)
  );

  // Reference model: pressed-polarity samples delayed two edges, a key flips
  // when its last D observed samples all disagree with its stable level, and
  // the publisher offers the stable chord whenever it differs from the last sent.
  logic [7:0] m_p1 = '0;
  logic [7:0] m_p2 = '0;
  logic [7:0] m_hist [D];
  logic [7:0] m_stable = '0;
  logic [7:0] m_chord = '0;
  logic [7:0] m_last = '0;
  logic       m_valid = 1'b0;
  logic       m_all;

  always @(posedge clk) begin
    if (rst) begin
      m_p1 = '0;
      m_p2 = '0;
      for (int j = 0; j < D; j++) m_hist[j] = '0;
      m_stable = '0;
      m_chord  = '0;
      m_last   = '0;
      m_valid  = 1'b0;
    end else begin
      if (m_valid) begin
        if (chord_ready) m_valid = 1'b0;
      end else if (m_stable != m_last) begin
        m_chord = m_stable;
        m_last  = m_stable;
        m_valid = 1'b1;
      end
      for (int j = D - 1; j > 0; j--) m_hist[j] = m_hist[j-1];
      m_hist[0] = m_p2;
      for (int k = 0; k < 8; k++) begin
        m_all = 1'b1;
        for (int j = 0; j < D; j++) if (m_hist[j][k] == m_stable[k]) m_all = 1'b0;
        if (m_all) m_stable[k] = ~m_stable[k];
      end
      m_p2 = m_p1;
      m_p1 = raw ^ IDLE_RAW;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    chord_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      raw = 8'($urandom);
      tick();
      total++;
      if ({keys_stable, chord, chord_valid} !== 17'h0) begin
        bad++;
        $display("FAIL reset_state c=%0d got ks=%h ch=%h v=%b want 00/00/0", c, keys_stable, chord, chord_valid);
      end
    end
    rst = 1'b0;
    raw = IDLE_RAW;
    for (int c = 0; c < 10; c++) begin
      tick();
      total++;
      if ({keys_stable, chord, chord_valid} !== {m_stable, m_chord, m_valid}) begin
        bad++;
        $display("FAIL reset_idle got ks=%h ch=%h v=%b want ks=%h ch=%h v=%b", keys_stable, chord, chord_valid, m_stable, m_chord, m_valid);
      end
    end
  endtask

  task automatic test_single_press();
    chord_ready = 1'b1;
    raw = IDLE_RAW ^ 8'h80;
    for (int t = 0; t < 10; t++) begin
      tick();
      total++;
      if (chord_valid !== (t == 6) || chord !== ((t >= 6) ? 8'h80 : 8'h00) ||
          keys_stable !== ((t >= 5) ? 8'h80 : 8'h00)) begin
        bad++;
        $display("FAIL single_press E%0d got ks=%h ch=%h v=%b want ks=%h ch=%h v=%b", t, keys_stable, chord, chord_valid,
                 (t >= 5) ? 8'h80 : 8'h00, (t >= 6) ? 8'h80 : 8'h00, (t == 6));
      end
      total++;
      if ({keys_stable, chord, chord_valid} !== {m_stable, m_chord, m_valid}) begin
        bad++;
        $display("FAIL single_press_model got ks=%h ch=%h v=%b want ks=%h ch=%h v=%b", keys_stable, chord, chord_valid, m_stable, m_chord, m_valid);
      end
    end
  endtask

  task automatic test_glitch();
    chord_ready = 1'b1;
    for (int c = 0; c < 15; c++) begin
      raw = IDLE_RAW ^ ((c < 3) ? 8'h90 : 8'h80);
      tick();
      total++;
      if (keys_stable !== 8'h80 || chord_valid !== 1'b0) begin
        bad++;
        $display("FAIL glitch c=%0d got ks=%h v=%b want ks=80 v=0", c, keys_stable, chord_valid);
      end
    end
  endtask

  task automatic test_coalesce();
    bit hit;
    chord_ready = 1'b1;
    raw = IDLE_RAW;
    for (int c = 0; c < 12; c++) begin
      tick();
      total++;
      if ({keys_stable, chord, chord_valid} !== {m_stable, m_chord, m_valid}) begin
        bad++;
        $display("FAIL coalesce_release got ks=%h ch=%h v=%b want ks=%h ch=%h v=%b", keys_stable, chord, chord_valid, m_stable, m_chord, m_valid);
      end
    end
    chord_ready = 1'b0;
    raw = IDLE_RAW ^ 8'h01;
    hit = 1'b0;
    for (int c = 0; c < 20 && !hit; c++) begin
      tick();
      hit = chord_valid;
    end
    total++;
    if (!hit || chord !== 8'h01) begin
      bad++;
      $display("FAIL coalesce_first got v=%b ch=%h want v=1 ch=01", hit, chord);
    end
    raw = IDLE_RAW ^ 8'h41;
    for (int c = 0; c < 12; c++) begin
      tick();
      total++;
      if (chord !== 8'h01 || chord_valid !== 1'b1) begin
        bad++;
        $display("FAIL coalesce_hold c=%0d got ch=%h v=%b want ch=01 v=1", c, chord, chord_valid);
      end
    end
    total++;
    if (keys_stable !== 8'h41) begin
      bad++;
      $display("FAIL coalesce_stable got %h want 41", keys_stable);
    end
    chord_ready = 1'b1;
    tick();
    total++;
    if (chord_valid !== 1'b0) begin
      bad++;
      $display("FAIL coalesce_bubble got v=%b want 0", chord_valid);
    end
    tick();
    total++;
    if (chord_valid !== 1'b1 || chord !== 8'h41) begin
      bad++;
      $display("FAIL coalesce_next got v=%b ch=%h want v=1 ch=41", chord_valid, chord);
    end
    tick();
    total++;
    if ({keys_stable, chord, chord_valid} !== {m_stable, m_chord, m_valid}) begin
      bad++;
      $display("FAIL coalesce_model got ks=%h ch=%h v=%b want ks=%h ch=%h v=%b", keys_stable, chord, chord_valid, m_stable, m_chord, m_valid);
    end
  endtask

  task automatic test_bounce();
    int pulses;
    chord_ready = 1'b1;
    raw = IDLE_RAW;
    for (int c = 0; c < 12; c++) tick();
    pulses = 0;
    for (int c = 0; c < 35; c++) begin
      raw = IDLE_RAW ^ ((c >= 20 || ((c / 2) % 2) == 0) ? 8'h04 : 8'h00);
      tick();
      if (chord_valid === 1'b1) pulses++;
      total++;
      if ({keys_stable, chord, chord_valid} !== {m_stable, m_chord, m_valid}) begin
        bad++;
        $display("FAIL bounce_model c=%0d got ks=%h ch=%h v=%b want ks=%h ch=%h v=%b", c, keys_stable, chord, chord_valid, m_stable, m_chord, m_valid);
      end
    end
    total++;
    if (pulses != 1 || chord !== 8'h04 || keys_stable !== 8'h04) begin
      bad++;
      $display("FAIL bounce_single got pulses=%0d ch=%h ks=%h want pulses=1 ch=04 ks=04", pulses, chord, keys_stable);
    end
  endtask

  task automatic test_reset_mid();
    bit hit;
    chord_ready = 1'b0;
    raw = IDLE_RAW ^ 8'h20;
    hit = 1'b0;
    for (int c = 0; c < 20 && !hit; c++) begin
      tick();
      hit = chord_valid;
    end
    total++;
    if (!hit || chord !== 8'h20) begin
      bad++;
      $display("FAIL t2_press got v=%b ch=%h want v=1 ch=20", hit, chord);
    end
    rst = 1'b1;
    tick();
    total++;
    if (chord_valid !== 1'b0 || chord !== 8'h00 || keys_stable !== 8'h00) begin
      bad++;
      $display("FAIL reset_mid got v=%b ch=%h ks=%h want 0/00/00", chord_valid, chord, keys_stable);
    end
    rst = 1'b0;
    raw = IDLE_RAW;
    chord_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      total++;
      if ({keys_stable, chord, chord_valid} !== {m_stable, m_chord, m_valid}) begin
        bad++;
        $display("FAIL reset_mid_model got ks=%h ch=%h v=%b want ks=%h ch=%h v=%b", keys_stable, chord, chord_valid, m_stable, m_chord, m_valid);
      end
    end
  endtask

  task automatic test_random();
    int idx;
    int offers;
    offers = 0;
    for (int c = 0; c < 600; c++) begin
      rst = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 3) == 0) begin
        idx = $urandom_range(0, 7);
        raw[idx] = ~raw[idx];
      end
      chord_ready = ($urandom_range(0, 2) != 0);
      tick();
      if (chord_valid === 1'b1) offers++;
      total++;
      if ({keys_stable, chord, chord_valid} !== {m_stable, m_chord, m_valid}) begin
        bad++;
        $display("FAIL random c=%0d got ks=%h ch=%h v=%b want ks=%h ch=%h v=%b", c, keys_stable, chord, chord_valid, m_stable, m_chord, m_valid);
      end
    end
    rst = 1'b0;
    total++;
    if (offers == 0) begin
      bad++;
      $display("FAIL random_activity got offers=0 want >0");
    end
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_glitch();
    test_coalesce();
    test_bounce();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

endmodule
